apple_gen: RTL and testbench



---
 rtl/snake_pkg.sv | 48 ++++
 rtl/lfsr16.sv | 38 +++
 rtl/apple_gen.sv | 184 ++++++++++++++++++
 tb/tb_apple_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game blocks.
//   - game_status codes (RESTART/START/PLAY)
//   - playable grid limits, cell size shift, screen size
//   - playfield cell codes
//   - apple placement FSM state enum
//   - LFSR tap mask and a small grid range helper
package snake_pkg;

  typedef enum logic [1:0] {
    GS_RESTART = 2'b00,
    GS_START   = 2'b01,
    GS_PLAY    = 2'b10
  } game_status_e;

  localparam int unsigned GRID_X_MIN = 1;
  localparam int unsigned GRID_X_MAX = 38;
  localparam int unsigned GRID_Y_MIN = 1;
  localparam int unsigned GRID_Y_MAX = 28;

  // One cell is 16x16 pixels.
  localparam int unsigned CELL_SHIFT = 4;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    CELL_NONE,
    CELL_HEAD,
    CELL_BODY,
    CELL_WALL
  } cell_e;

  typedef enum logic [1:0] {
    ST_PLACE,
    ST_ACTIVE,
    ST_EATEN
  } apple_state_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic in_range(input logic [5:0] v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (v >= 6'(lo)) && (v <= 6'(hi));
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Advances on every clock edge while out of reset.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset (loads SEED)
//   state - current LFSR state
// SEED must be non-zero.
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/apple_gen.sv
// apple_gen: places the apple on the playfield, detects the snake head
// eating it, emits the add_cube growth pulse, keeps the score and
// relocates the apple pseudo-randomly.
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   game_status  - 00 RESTART, 01 START, 10 PLAY (11 behaves as START)
//   head_x/y     - snake head cell
//   x_pos/y_pos  - current VGA pixel
//   add_cube     - registered growth request, ADD_HOLD cycles per eat
//   apple_x/y    - apple cell
//   apple_valid  - apple currently on the board
//   apple_pix    - current pixel lies inside the apple cell
//   score        - apples eaten, saturating
// Optional feature: define APPLE_TIMEOUT_EN to relocate an uneaten apple
// after TIMEOUT_CYCLES cycles of PLAY in ACTIVE.
module apple_gen
  import snake_pkg::*;
#(
  parameter int unsigned X_MIN          = GRID_X_MIN,
  parameter int unsigned X_MAX          = GRID_X_MAX,
  parameter int unsigned Y_MIN          = GRID_Y_MIN,
  parameter int unsigned Y_MAX          = GRID_Y_MAX,
  parameter int unsigned ADD_HOLD       = 4,
  parameter int unsigned MAX_GROW       = 13,
  parameter int unsigned SCORE_W        = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         game_status,
  input  logic [5:0]         head_x,
  input  logic [5:0]         head_y,
  input  logic [9:0]         x_pos,
  input  logic [9:0]         y_pos,
  output logic               add_cube,
  output logic [5:0]         apple_x,
  output logic [5:0]         apple_y,
  output logic               apple_valid,
  output logic               apple_pix,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned HOLD_W = $clog2(ADD_HOLD + 1);
  // +2 keeps the width non-zero and lets grow_cnt reach MAX_GROW.
  localparam int unsigned GROW_W = $clog2(MAX_GROW + 2);

  logic [15:0] lfsr;
  logic [5:0]  cand_x;
  logic [5:0]  cand_y;
  logic        cand_ok;
  logic        eat;
  logic        lfsr_unused;

  apple_state_e        state_q;
  logic                add_q;
  logic [5:0]          apple_x_q;
  logic [5:0]          apple_y_q;
  logic                valid_q;
  logic [SCORE_W-1:0]  score_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [GROW_W-1:0]   grow_q;

`ifdef APPLE_TIMEOUT_EN
  localparam int unsigned TIMER_W = 29;
  logic [TIMER_W-1:0] timer_q;
  logic               timeout;
  assign timeout = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
`endif

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign cand_x      = lfsr[5:0];
  assign cand_y      = lfsr[13:8];
  assign lfsr_unused = ^{lfsr[15:14], lfsr[7:6]};

  always_comb begin
    cand_ok = in_range(cand_x, X_MIN, X_MAX) &&
              in_range(cand_y, Y_MIN, Y_MAX) &&
              !((cand_x == head_x) && (cand_y == head_y));
  end

  assign eat = (state_q == ST_ACTIVE) && (game_status == GS_PLAY) &&
               (head_x == apple_x_q) && (head_y == apple_y_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_PLACE;
      add_q     <= 1'b0;
      apple_x_q <= '0;
      apple_y_q <= '0;
      valid_q   <= 1'b0;
      score_q   <= '0;
      hold_q    <= '0;
      grow_q    <= '0;
`ifdef APPLE_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else if (game_status == GS_RESTART) begin
      // Apple coordinates are deliberately kept across a restart.
      state_q <= ST_PLACE;
      add_q   <= 1'b0;
      valid_q <= 1'b0;
      score_q <= '0;
      hold_q  <= '0;
      grow_q  <= '0;
`ifdef APPLE_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_PLACE: begin
          if (cand_ok) begin
            apple_x_q <= cand_x;
            apple_y_q <= cand_y;
            valid_q   <= 1'b1;
            state_q   <= ST_ACTIVE;
`ifdef APPLE_TIMEOUT_EN
            timer_q   <= '0;
`endif
          end
        end

        ST_ACTIVE: begin
          if (eat) begin
            valid_q <= 1'b0;
            if (score_q != '1) begin
              score_q <= score_q + 1'b1;
            end
            // grow_cnt saturates at MAX_GROW; only its comparison matters.
            if (grow_q < GROW_W'(MAX_GROW)) begin
              add_q  <= 1'b1;
              grow_q <= grow_q + 1'b1;
            end
            hold_q  <= HOLD_W'(ADD_HOLD - 1);
            state_q <= ST_EATEN;
          end
`ifdef APPLE_TIMEOUT_EN
          else if (game_status == GS_PLAY) begin
            if (timeout) begin
              valid_q <= 1'b0;
              state_q <= ST_PLACE;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
`endif
        end

        ST_EATEN: begin
          if (hold_q == '0) begin
            add_q   <= 1'b0;
            state_q <= ST_PLACE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end

        default: state_q <= ST_PLACE;
      endcase
    end
  end

  assign add_cube    = add_q;
  assign apple_x     = apple_x_q;
  assign apple_y     = apple_y_q;
  assign apple_valid = valid_q;
  assign score       = score_q;

  assign apple_pix = valid_q &&
                     (x_pos < 10'(SCREEN_W)) && (y_pos < 10'(SCREEN_H)) &&
                     (x_pos[9:CELL_SHIFT] == apple_x_q) &&
                     (y_pos[9:CELL_SHIFT] == apple_y_q);

endmodule

// File: tb/tb_apple_gen.sv
module tb_apple_gen;

  localparam int SEED  = 16'hACE1;
  localparam int TMO   = 100;
  localparam int HOLD  = 4;
  localparam int GROWS = 13;
  localparam int SMAX  = 255;

  localparam int PH_PLACE  = 0;
  localparam int PH_ACTIVE = 1;
  localparam int PH_EATEN  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] gs;
  logic [5:0] hx, hy;
  logic [9:0] xp, yp;
  logic       add_cube, apple_valid, apple_pix;
  logic [5:0] apple_x, apple_y;
  logic [7:0] score;

  apple_gen #(
    .ADD_HOLD       (HOLD),
    .MAX_GROW       (GROWS),
    .SCORE_W        (8),
    .LFSR_SEED      (16'hACE1),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_status (gs),
    .head_x      (hx),
    .head_y      (hy),
    .x_pos       (xp),
    .y_pos       (yp),
    .add_cube    (add_cube),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .apple_valid (apple_valid),
    .apple_pix   (apple_pix),
    .score       (score)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit [15:0] m_lfsr;
  int        m_phase, m_hold, m_eats_grow, m_score, m_ax, m_ay, m_timer;
  bit        m_valid, m_add;
  int        dut_pulses;
  bit        add_prev;

  function automatic bit [15:0] lfsr_next(input bit [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_lfsr = 16'(SEED);
    m_phase = PH_PLACE; m_hold = 0; m_eats_grow = 0; m_score = 0;
    m_ax = 0; m_ay = 0; m_timer = 0; m_valid = 0; m_add = 0;
  endtask

  task automatic model_edge();
    int cx, cy;
    bit [15:0] cur;
    cur = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    cx = int'(cur[5:0]);
    cy = int'(cur[13:8]);
    if (gs == 2'b00) begin
      m_phase = PH_PLACE; m_add = 0; m_valid = 0; m_score = 0;
      m_eats_grow = 0; m_hold = 0; m_timer = 0;
    end else if (m_phase == PH_PLACE) begin
      if (cx >= 1 && cx <= 38 && cy >= 1 && cy <= 28 &&
          !(cx == int'(hx) && cy == int'(hy))) begin
        m_ax = cx; m_ay = cy; m_valid = 1; m_phase = PH_ACTIVE; m_timer = 0;
      end
    end else if (m_phase == PH_ACTIVE) begin
      if (gs == 2'b10 && int'(hx) == m_ax && int'(hy) == m_ay) begin
        m_valid = 0;
        if (m_score < SMAX) m_score++;
        if (m_eats_grow < GROWS) m_add = 1;
        m_eats_grow++;
        m_hold = HOLD - 1;
        m_phase = PH_EATEN;
      end
`ifdef APPLE_TIMEOUT_EN
      else if (gs == 2'b10) begin
        if (m_timer == TMO - 1) begin
          m_valid = 0; m_phase = PH_PLACE;
        end else begin
          m_timer++;
        end
      end
`endif
    end else begin
      if (m_hold == 0) begin
        m_add = 0; m_phase = PH_PLACE;
      end else begin
        m_hold--;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit pix;
    pix = m_valid && xp < 640 && yp < 480 &&
          (int'(xp) / 16) == m_ax && (int'(yp) / 16) == m_ay;
    chk("add_cube", add_cube, int'(m_add));
    chk("apple_valid", apple_valid, int'(m_valid));
    chk("apple_x", apple_x, m_ax);
    chk("apple_y", apple_y, m_ay);
    chk("score", score, m_score);
    chk("apple_pix", apple_pix, int'(pix));
  endtask

  task automatic rand_pixel();
    if ($urandom_range(1, 0) == 1) begin
      xp = 10'(m_ax * 16 + $urandom_range(15, 0));
      yp = 10'(m_ay * 16 + $urandom_range(15, 0));
    end else begin
      xp = 10'($urandom_range(1023, 0));
      yp = 10'($urandom_range(1023, 0));
    end
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    #1;
    check_all();
    if (add_cube && !add_prev) dut_pulses++;
    add_prev = add_cube;
    rand_pixel();
  endtask

  // Head parked on a column no apple can occupy.
  task automatic head_away();
    hx = 6'($urandom_range(63, 39));
    hy = 6'($urandom_range(63, 0));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 400 && !m_valid; i++) cycle();
    chk(tag, apple_valid, 1);
  endtask

  task automatic eat_once();
    wait_valid("eat_wait_valid");
    gs = 2'b10;
    hx = 6'(m_ax);
    hy = 6'(m_ay);
    cycle();
    head_away();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int saved_x, saved_y;
    gs = 2'b00; hx = 6'd10; hy = 6'd5; xp = '0; yp = '0;
    dut_pulses = 0; add_prev = 0;
    model_reset();
    #12;
    check_all();

    // Placement in START with head at (10,5)
    @(negedge clk);
    rst = 1'b1;
    gs = 2'b01;
    for (int i = 0; i < 64 && !apple_valid; i++) cycle();
    chk("start_place_valid", apple_valid, 1);
    chk("start_x_range", 32'(apple_x >= 1 && apple_x <= 38), 1);
    chk("start_y_range", 32'(apple_y >= 1 && apple_y <= 28), 1);
    chk("start_not_head", 32'(!(apple_x == 10 && apple_y == 5)), 1);

    // START never eats
    hx = 6'(m_ax); hy = 6'(m_ay);
    repeat (3) cycle();
    chk("start_no_eat_score", score, 0);
    head_away();

    // First eat: pulse length and relocation
    eat_once();
    len = 0;
    while (add_cube && len < 10) begin len++; cycle(); end
    chk("first_pulse_len", len, HOLD);
    chk("first_score", score, 1);
    wait_valid("first_replace");
    chk("replace_x_range", 32'(apple_x >= 1 && apple_x <= 38), 1);
    chk("replace_y_range", 32'(apple_y >= 1 && apple_y <= 28), 1);

    // Remaining eats up to 14, with random idle gaps
    for (int e = 1; e < 14; e++) begin
      repeat ($urandom_range(4, 0)) begin
        gs = ($urandom_range(3, 0) == 0) ? 2'b11 : 2'b10;
        head_away();
        cycle();
      end
      eat_once();
    end
    repeat (HOLD + 2) cycle();
    chk("pulses_after_14", dut_pulses, GROWS);
    chk("score_after_14", score, 14);

    // Saturation
    for (int e = 14; e < 300; e++) eat_once();
    repeat (HOLD + 2) cycle();
    chk("score_saturated", score, SMAX);
    chk("pulses_after_300", dut_pulses, GROWS);

    // RESTART coinciding with an eat
    wait_valid("restart_wait_valid");
    saved_x = m_ax; saved_y = m_ay;
    hx = 6'(m_ax); hy = 6'(m_ay);
    gs = 2'b00;
    cycle();
    chk("restart_add", add_cube, 0);
    chk("restart_score", score, 0);
    chk("restart_valid", apple_valid, 0);
    chk("restart_hold_x", apple_x, saved_x);
    chk("restart_hold_y", apple_y, saved_y);
    head_away();
    gs = 2'b01;
    wait_valid("restart_replace");

    // Fresh growth budget after restart
    dut_pulses = 0;
    eat_once();
    cycle();
    chk("restart_regrow", add_cube, 1);

    // Async reset while in EATEN
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_add", add_cube, 0);
    chk("async_rst_score", score, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    gs = 2'b10;
    wait_valid("post_reset_place");

`ifdef APPLE_TIMEOUT_EN
    // Timeout: head never on apple, count valid cycles in ACTIVE
    repeat (HOLD + 2) cycle();
    wait_valid("tmo_wait_valid");
    saved_x = m_score;
    len = 0;
    while (apple_valid && len < TMO + 20) begin len++; cycle(); end
    chk("timeout_len", len, TMO);
    chk("timeout_score", score, saved_x);
    chk("timeout_add", add_cube, 0);
    wait_valid("timeout_replace");
`endif

    // Random mixed traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(9, 0))
        0:       gs = 2'b00;
        1, 2:    gs = 2'b01;
        3:       gs = 2'b11;
        default: gs = 2'b10;
      endcase
      if ($urandom_range(2, 0) == 0 && m_valid) begin
        hx = 6'(m_ax); hy = 6'(m_ay);
      end else begin
        hx = 6'($urandom_range(63, 0)); hy = 6'($urandom_range(63, 0));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
